// File: rtl/tb_clock_monitor.sv
// Measures high/low time of the asynchronous clock MON in CLK cycles and checks them against windows.
// Optional macro TB_CLKMON_STUCK_EN: counter saturation raises err_stuck and restarts the edge search.
module tb_clock_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       tb_status,
    input  logic             MON,
    input  logic [CNT_W-1:0] exp_high_min,
    input  logic [CNT_W-1:0] exp_high_max,
    input  logic [CNT_W-1:0] exp_low_min,
    input  logic [CNT_W-1:0] exp_low_max,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             meas_valid,
    output logic             err_high,
    output logic             err_low,
    output logic             err_stuck,
    output logic             locked,
    output logic [31:0]      rise_count
);

    // A single-stage synchronizer is never safe, so shallower settings are raised to two.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [STAGES-1:0] sync_q;
    logic              edge_q;
    logic              mon_rise;
    logic              mon_fall;
    logic              enable;
    logic              status_unused;
    logic [CNT_W-1:0]  counter;
    logic              cnt_sat;
    logic              counting;
    logic              load_cnt;
    logic              latch_high;
    logic              latch_low;
    logic              take_rise;
    logic              clear_err;
    logic              high_bad;
    logic              low_bad;
    logic              prev_ok;
`ifdef TB_CLKMON_STUCK_EN
    logic              stuck_hit;
`endif

    assign enable        = tb_status[0];
    assign status_unused = tb_status[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], MON};
            edge_q <= sync_q[STAGES-1];
        end
    end

    assign mon_rise = sync_q[STAGES-1] & ~edge_q;
    assign mon_fall = ~sync_q[STAGES-1] & edge_q;
    assign cnt_sat  = (counter == CNT_MAX);
    assign counting = (state == MEAS_HIGH) || (state == MEAS_LOW);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Disable is checked first so it overrides any edge arriving in the same cycle.
    always_comb begin
        next_state = state;
        load_cnt   = 1'b0;
        latch_high = 1'b0;
        latch_low  = 1'b0;
        take_rise  = 1'b0;
        clear_err  = 1'b0;
`ifdef TB_CLKMON_STUCK_EN
        stuck_hit  = 1'b0;
`endif
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    next_state = WAIT_EDGE;
                    clear_err  = 1'b1;
                end
                WAIT_EDGE: begin
                    if (mon_rise) begin
                        next_state = MEAS_HIGH;
                        load_cnt   = 1'b1;
                        take_rise  = 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    if (mon_fall) begin
                        next_state = MEAS_LOW;
                        load_cnt   = 1'b1;
                        latch_high = 1'b1;
                    end
`ifdef TB_CLKMON_STUCK_EN
                    else if (cnt_sat) begin
                        next_state = WAIT_EDGE;
                        stuck_hit  = 1'b1;
                    end
`endif
                end
                MEAS_LOW: begin
                    if (mon_rise) begin
                        next_state = MEAS_HIGH;
                        load_cnt   = 1'b1;
                        latch_low  = 1'b1;
                        take_rise  = 1'b1;
                    end
`ifdef TB_CLKMON_STUCK_EN
                    else if (cnt_sat) begin
                        next_state = WAIT_EDGE;
                        stuck_hit  = 1'b1;
                    end
`endif
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            counter    <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            rise_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= latch_low;
            if (load_cnt) begin
                counter <= CNT_ONE;
            end else if (!enable) begin
                counter <= '0;
            end else if (counting && !cnt_sat) begin
                counter <= counter + CNT_ONE;
            end
            if (latch_high) begin
                high_cnt <= counter;
            end
            if (latch_low) begin
                low_cnt <= counter;
            end
            if (take_rise) begin
                rise_count <= rise_count + 32'd1;
            end
        end
    end

    // The low time is judged from the live counter because low_cnt only takes it on this same edge.
    assign high_bad = (high_cnt < exp_high_min) || (high_cnt > exp_high_max);
    assign low_bad  = (counter < exp_low_min) || (counter > exp_low_max);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_high <= 1'b0;
            err_low  <= 1'b0;
        end else if (clear_err) begin
            err_high <= 1'b0;
            err_low  <= 1'b0;
        end else if (latch_low) begin
            if (high_bad) begin
                err_high <= 1'b1;
            end
            if (low_bad) begin
                err_low <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            locked  <= 1'b0;
            prev_ok <= 1'b0;
        end else if (!enable || clear_err) begin
            locked  <= 1'b0;
            prev_ok <= 1'b0;
        end else if (latch_low) begin
            if (!high_bad && !low_bad) begin
                if (prev_ok) begin
                    locked <= 1'b1;
                end
                prev_ok <= 1'b1;
            end else begin
                locked  <= 1'b0;
                prev_ok <= 1'b0;
            end
        end
`ifdef TB_CLKMON_STUCK_EN
        else if (stuck_hit) begin
            locked  <= 1'b0;
            prev_ok <= 1'b0;
        end
`endif
    end

`ifdef TB_CLKMON_STUCK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_stuck <= 1'b0;
        end else if (clear_err) begin
            err_stuck <= 1'b0;
        end else if (stuck_hit) begin
            err_stuck <= 1'b1;
        end
    end
`else
    assign err_stuck = 1'b0;
`endif

endmodule
